// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit and its buffer:
//   NOP_INSTR      - word presented toward decode when nothing is valid
//   PC_STEP        - byte increment between consecutive fetch addresses
//   fetch_state_t  - fetch control states (BOOT, RUN, TRAP)
//   fetch_entry_t  - one buffered instruction word plus its PC
//   align_pc()     - clears the two byte-offset bits of a PC
// ---------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    TRAP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// DEPTH-entry synchronous FIFO of {instr, pc}. No fall-through: a word pushed
// in one cycle is visible at the head from the next cycle on. Push and pop in
// the same cycle are both honoured, including when full. Flush empties the
// FIFO and overrides any same-cycle push or pop.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   flush_i           - discard all entries
//   push_i, push_entry_i - write one entry
//   pop_i             - remove the head entry
//   head_o            - head entry (meaningful only when count_o != 0)
//   count_o           - number of valid entries
// ---------------------------------------------------------------------------
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_entry_t     push_entry_i,
  input  logic             pop_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign push_ok = push_i && ((count_q != CNT_W'(DEPTH)) || pop_ok);

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of all others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
// Producer of the instruction stream toward decode. Keeps the fetch PC,
// issues word requests to instruction memory, buffers returned words in order
// and presents {instr, instr_pc} with a valid/ready handshake. A redirect
// flushes the buffer, restarts fetch at the new PC and drops every response
// still in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   - adds instr_misaligned; a redirect to a non word-aligned PC
//               enters TRAP and presents a single NOP marked misaligned
//   undefined - the low two redirect PC bits are silently cleared
// Ports:
//   clk, rst_n                          - clock, synchronous active-low reset
//   imem_req_valid/ready/addr           - request channel to memory
//   imem_rsp_valid/data                 - in-order response channel
//   instr_valid/ready, instr, instr_pc  - decode handshake and payload
//   instr_misaligned                    - trap marker (feature only)
//   redirect_valid, redirect_pc         - flush and restart fetch
// ---------------------------------------------------------------------------
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        instr_misaligned,
`endif
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      rsp_pc_q, rsp_pc_d;     // PC of the next word to be kept
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic             req_fire;
  logic             rsp_fire;
  logic             rsp_keep;
  logic             buf_push;
  logic             buf_pop;
  fetch_entry_t     buf_head;
  logic [CNT_W-1:0] buf_count;
  logic             buf_nonempty;

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  // NOTE: every combinational block assigns defaults first so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      TRAP:    state_d = TRAP;
      default: state_d = BOOT;
    endcase
    if (redirect_valid) begin
      state_d = RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (redirect_pc[1:0] != 2'b00) state_d = TRAP;
`endif
    end
  end

  // Requests are issued only in RUN and only while a slot is guaranteed for
  // the returning word, so the buffer can never overflow.
  always_comb begin
    imem_req_valid = 1'b0;
    if (state_q == RUN) begin
      imem_req_valid = ((CNT_W+1)'(inflight_q) + (CNT_W+1)'(buf_count) < (CNT_W+1)'(DEPTH))
                       && !redirect_valid;
    end
  end

  assign imem_req_addr = fetch_pc_q;

  // ----------------------------------------------------------- datapath ----
  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding can only be a leftover from before
  // reset; ignoring it keeps the counters from wrapping.
  assign rsp_fire = imem_rsp_valid && (inflight_q != '0);
  assign rsp_keep = rsp_fire && (drop_cnt_q == '0);

  always_comb begin
    inflight_d = inflight_q + CNT_W'(req_fire) - CNT_W'(rsp_fire);
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      // Everything still outstanding after this cycle is stale.
      fetch_pc_d = align_pc(redirect_pc);
      rsp_pc_d   = align_pc(redirect_pc);
      drop_cnt_d = inflight_q - CNT_W'(rsp_fire);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_STEP;
      if (rsp_keep) rsp_pc_d   = rsp_pc_q + PC_STEP;
      if (rsp_fire && !rsp_keep) drop_cnt_d = drop_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // ------------------------------------------------------------- buffer ----
  assign buf_nonempty = (buf_count != '0);
  assign buf_push     = rsp_keep && !redirect_valid;
  assign buf_pop      = buf_nonempty && instr_ready && !redirect_valid;

  fetch_buffer #(
    .DEPTH (DEPTH)
  ) u_buffer (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (redirect_valid),
    .push_i       (buf_push),
    .push_entry_i ('{instr: imem_rsp_data, pc: rsp_pc_q}),
    .pop_i        (buf_pop),
    .head_o       (buf_head),
    .count_o      (buf_count)
  );

`ifdef FETCH_MISALIGN_TRAP_EN
  // -------------------------------------------------------- trap entry ----
  logic        trap_wait_q, trap_wait_d;    // waiting for stale drops to drain
  logic        trap_valid_q, trap_valid_d;  // trap entry presented to decode
  logic [31:0] trap_pc_q, trap_pc_d;

  always_comb begin
    trap_wait_d  = trap_wait_q;
    trap_valid_d = trap_valid_q;
    trap_pc_d    = trap_pc_q;
    if (redirect_valid) begin
      trap_wait_d  = (redirect_pc[1:0] != 2'b00);
      trap_valid_d = 1'b0;
      trap_pc_d    = redirect_pc;
    end else begin
      if (trap_wait_q && (drop_cnt_q == '0)) begin
        trap_wait_d  = 1'b0;
        trap_valid_d = 1'b1;
      end
      if (trap_valid_q && instr_ready) trap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trap_wait_q  <= 1'b0;
      trap_valid_q <= 1'b0;
      trap_pc_q    <= RESET_PC;
    end else begin
      trap_wait_q  <= trap_wait_d;
      trap_valid_q <= trap_valid_d;
      trap_pc_q    <= trap_pc_d;
    end
  end

  // The buffer is always empty in TRAP, so the trap entry never competes
  // with a buffered word.
  always_comb begin
    instr_valid      = buf_nonempty || trap_valid_q;
    instr            = buf_nonempty ? buf_head.instr : NOP_INSTR;
    instr_pc         = buf_nonempty ? buf_head.pc    : rsp_pc_q;
    instr_misaligned = trap_valid_q;
    if (trap_valid_q) begin
      instr    = NOP_INSTR;
      instr_pc = trap_pc_q;
    end
  end
`else
  always_comb begin
    instr_valid = buf_nonempty;
    instr       = buf_nonempty ? buf_head.instr : NOP_INSTR;
    instr_pc    = buf_nonempty ? buf_head.pc    : rsp_pc_q;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
// Self-checking bench for instr_fetch_unit. A queue-based memory model
// returns word = mem_word(addr) in order after a programmable latency; the
// expected decode stream is the contiguous PC sequence from the fetch start
// or the last redirect target. A second instance with RESET_PC=0xFFFF_FFF8
// and a fixed 1-cycle memory covers address wrap.
// Honours FETCH_MISALIGN_TRAP_EN when defined.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instr, instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mis;

  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_instr_valid;
  logic [31:0] w_instr, w_instr_pc;
  logic        w_mis;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; logic mis; } pop_t;

  mreq_t memq[$];
  pop_t  pops[$];
  pop_t  w_pops[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_cnt = 0;
  int max_out = 0;
  int mem_lat = 1;
  bit rand_lat = 0;
  int rdy_pct = 100;
  int dec_pct = 100;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .instr_misaligned (mis),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .instr_valid    (w_instr_valid),
    .instr_ready    (1'b1),
    .instr          (w_instr),
    .instr_pc       (w_instr_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
    .instr_misaligned (w_mis),
`endif
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0)
  );

`ifndef FETCH_MISALIGN_TRAP_EN
  assign mis   = 1'b0;
  assign w_mis = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fixed 1-cycle memory for the wrap instance, always ready.
  always @(posedge clk) begin
    if (!rst_n) begin
      w_rsp_valid <= 1'b0;
      w_rsp_data  <= 32'h0;
    end else begin
      w_rsp_valid <= w_req_valid;
      w_rsp_data  <= mem_word(w_req_addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs at the falling edge, observe handshakes
  // 1 time unit later. mode 0: no redirect, 1: redirect, 2: redirect only if
  // a response, a valid head and a decode accept coincide this cycle.
  task automatic step(input int mode, input logic [31:0] rpc, output bit fired);
    int lat;
    @(negedge clk);
    imem_req_ready = ($urandom_range(99) < rdy_pct);
    instr_ready    = ($urandom_range(99) < dec_pct);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(memq[0].addr);
      memq.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    fired = (mode == 1) || (mode == 2 && imem_rsp_valid && instr_valid && instr_ready);
    redirect_valid = fired;
    redirect_pc    = fired ? rpc : $urandom;
    #1;
    if (imem_req_valid && imem_req_ready) begin
      lat = rand_lat ? int'($urandom_range(mem_lat, 1)) : mem_lat;
      memq.push_back('{addr: imem_req_addr, due: cyc + lat});
      req_cnt++;
    end
    if (memq.size() > max_out) max_out = memq.size();
    if (instr_valid && instr_ready && !redirect_valid)
      pops.push_back('{pc: instr_pc, ins: instr, mis: mis});
    if (w_instr_valid)
      w_pops.push_back('{pc: w_instr_pc, ins: w_instr, mis: w_mis});
    cyc++;
  endtask

  task automatic run(input int n);
    bit f;
    repeat (n) step(0, 32'h0, f);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    memq.delete();
    run(3);
    memq.delete();
    pops.delete();
    w_pops.delete();
    req_cnt = 0;
    max_out = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    mem_lat = 1; rand_lat = 0; rdy_pct = 100; dec_pct = 0;
    run(8);
    do_reset();
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL reset_req_valid got=%0b want=0", imem_req_valid); end
    total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL reset_req_addr got=%h want=00000000", imem_req_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_instr_valid got=%0b want=0", instr_valid); end
    total++; if (instr !== NOP) begin bad++; $display("FAIL reset_instr got=%h want=%h", instr, NOP); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr_pc got=%h want=00000000", instr_pc); end
    total++; if (mis !== 1'b0) begin bad++; $display("FAIL reset_misaligned got=%0b want=0", mis); end
    dec_pct = 100;
    run(1);
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      bad++; $display("FAIL first_request valid=%0b addr=%h want valid=1 addr=00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    do_reset();
    mem_lat = 1; rand_lat = 0; rdy_pct = 100; dec_pct = 100;
    run(40);
    total++; if (pops.size() < 10) begin bad++; $display("FAIL stream_count got=%0d want>=10", pops.size()); end
    for (int i = 0; i < pops.size(); i++) begin
      logic [31:0] epc;
      epc = 32'(4 * i);
      total++;
      if (pops[i].pc !== epc || pops[i].ins !== mem_word(epc) || pops[i].mis !== 1'b0) begin
        bad++; $display("FAIL stream_pop%0d pc=%h ins=%h want pc=%h ins=%h", i, pops[i].pc, pops[i].ins, epc, mem_word(epc));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    mem_lat = 1; rand_lat = 0; rdy_pct = 100; dec_pct = 0;
    run(12);
    total++; if (req_cnt != 2 || memq.size() != 0 || pops.size() != 0) begin
      bad++; $display("FAIL hold_requests reqs=%0d outstanding=%0d pops=%0d want 2/0/0", req_cnt, memq.size(), pops.size());
    end
    total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL hold_req_valid got=%0b want=0", imem_req_valid); end
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL hold_head valid=%0b pc=%h want 1/00000000", instr_valid, instr_pc);
    end
    dec_pct = 100;
    run(30);
    total++; if (pops.size() < 6) begin bad++; $display("FAIL release_count got=%0d want>=6", pops.size()); end
    for (int i = 0; i < pops.size(); i++) begin
      logic [31:0] epc;
      epc = 32'(4 * i);
      total++;
      if (pops[i].pc !== epc || pops[i].ins !== mem_word(epc)) begin
        bad++; $display("FAIL release_pop%0d pc=%h ins=%h want pc=%h", i, pops[i].pc, pops[i].ins, epc);
      end
    end
  endtask

  task automatic test_redirect_stale();
    bit f;
    do_reset();
    mem_lat = 3; rand_lat = 0; rdy_pct = 100; dec_pct = 100;
    for (int i = 0; i < 20; i++) begin
      run(1);
      if (memq.size() == 2) break;
    end
    total++; if (memq.size() != 2) begin bad++; $display("FAIL stale_setup outstanding=%0d want=2", memq.size()); end
    step(1, 32'h0000_0100, f);
    pops.delete();
    run(30);
    total++; if (pops.size() < 3) begin bad++; $display("FAIL stale_count got=%0d want>=3", pops.size()); end
    for (int i = 0; i < pops.size(); i++) begin
      logic [31:0] epc;
      epc = 32'h100 + 32'(4 * i);
      total++;
      if (pops[i].pc !== epc || pops[i].ins !== mem_word(epc)) begin
        bad++; $display("FAIL stale_pop%0d pc=%h ins=%h want pc=%h", i, pops[i].pc, pops[i].ins, epc);
      end
    end
    total++; if (max_out > DEPTH) begin bad++; $display("FAIL stale_inflight max=%0d want<=%0d", max_out, DEPTH); end
  endtask

  task automatic test_redirect_collide();
    bit f;
    do_reset();
    mem_lat = 2; rand_lat = 0; rdy_pct = 100; dec_pct = 100;
    run(6);
    f = 1'b0;
    for (int i = 0; i < 40 && !f; i++) step(2, 32'h0000_0300, f);
    total++; if (!f) begin bad++; $display("FAIL collide_setup found=0 want=1"); end
    pops.delete();
    @(posedge clk); #1;
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL collide_flush instr_valid=%0b want=0", instr_valid); end
    run(25);
    total++; if (pops.size() < 3) begin bad++; $display("FAIL collide_count got=%0d want>=3", pops.size()); end
    for (int i = 0; i < pops.size(); i++) begin
      logic [31:0] epc;
      epc = 32'h300 + 32'(4 * i);
      total++;
      if (pops[i].pc !== epc || pops[i].ins !== mem_word(epc)) begin
        bad++; $display("FAIL collide_pop%0d pc=%h ins=%h want pc=%h", i, pops[i].pc, pops[i].ins, epc);
      end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    do_reset();
    run(15);
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    total++; if (w_pops.size() < 3) begin bad++; $display("FAIL wrap_count got=%0d want>=3", w_pops.size()); end
    for (int i = 0; i < 3 && i < w_pops.size(); i++) begin
      total++;
      if (w_pops[i].pc !== exp_pc[i] || w_pops[i].ins !== mem_word(exp_pc[i])) begin
        bad++; $display("FAIL wrap_pop%0d pc=%h ins=%h want pc=%h", i, w_pops[i].pc, w_pops[i].ins, exp_pc[i]);
      end
    end
  endtask

  task automatic test_misalign();
    bit f;
    logic [31:0] base;
    do_reset();
    mem_lat = 2; rand_lat = 0; rdy_pct = 100; dec_pct = 100;
    run(10);
    step(1, 32'h0000_0102, f);
    pops.delete();
    req_cnt = 0;
    run(20);
`ifdef FETCH_MISALIGN_TRAP_EN
    total++; if (pops.size() != 1) begin bad++; $display("FAIL trap_count got=%0d want=1", pops.size()); end
    if (pops.size() > 0) begin
      total++;
      if (pops[0].pc !== 32'h102 || pops[0].ins !== NOP || pops[0].mis !== 1'b1) begin
        bad++; $display("FAIL trap_entry pc=%h ins=%h mis=%0b want 00000102/%h/1", pops[0].pc, pops[0].ins, pops[0].mis, NOP);
      end
    end
    total++; if (req_cnt != 0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL trap_idle reqs=%0d instr_valid=%0b want 0/0", req_cnt, instr_valid);
    end
    step(1, 32'h0000_0200, f);
    pops.delete();
    run(20);
    base = 32'h200;
`else
    base = 32'h100;
`endif
    total++; if (pops.size() < 3) begin bad++; $display("FAIL resume_count got=%0d want>=3", pops.size()); end
    for (int i = 0; i < pops.size(); i++) begin
      logic [31:0] epc;
      epc = base + 32'(4 * i);
      total++;
      if (pops[i].pc !== epc || pops[i].ins !== mem_word(epc) || pops[i].mis !== 1'b0) begin
        bad++; $display("FAIL resume_pop%0d pc=%h ins=%h want pc=%h", i, pops[i].pc, pops[i].ins, epc);
      end
    end
  endtask

  task automatic test_random();
    bit f;
    int mode;
    int seen;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    do_reset();
    mem_lat = 4; rand_lat = 1; rdy_pct = 70; dec_pct = 60;
    exp_pc = 32'h0;
    seen = 0;
    for (int c = 0; c < 500; c++) begin
      mode = ($urandom_range(99) < 4) ? 1 : 0;
      rpc  = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc = rpc & 32'hFFFF_FFFC;
`endif
      step(mode, rpc, f);
      while (pops.size() > 0) begin
        total++;
        if (pops[0].pc !== exp_pc || pops[0].ins !== mem_word(exp_pc) || pops[0].mis !== 1'b0) begin
          bad++; $display("FAIL random_pop%0d pc=%h ins=%h want pc=%h", seen, pops[0].pc, pops[0].ins, exp_pc);
        end
        pops.delete(0);
        exp_pc = exp_pc + 32'd4;
        seen++;
      end
      if (f) exp_pc = rpc & 32'hFFFF_FFFC;
    end
    total++; if (seen < 50) begin bad++; $display("FAIL random_progress pops=%0d want>=50", seen); end
    total++; if (max_out > DEPTH) begin bad++; $display("FAIL random_inflight max=%0d want<=%0d", max_out, DEPTH); end
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_stale();
    test_redirect_collide();
    test_wrap();
    test_misalign();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Producer side of the instruction stream that the opcode decoder consumes. Keeps the fetch PC and issues word requests to instruction memory. Holds returned words in a small in-order buffer and presents {instr, instr_pc} to decode with a valid/ready handshake. Accepts PC redirects from branch/jump resolution and discards all stale in-flight data.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 2, buffer entries; also the cap on in-flight requests plus buffered words (power of two, >=2)

Ports:
clk  input  1  core clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk edge
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_rsp_valid  input  1  response word valid; in order, >=1 cycle after acceptance
imem_rsp_data  input  32  response instruction word
instr_valid  output  1  buffer head valid toward decode
instr_ready  input  1  decode accepts head
instr  output  32  head instruction word
instr_pc  output  32  PC of head word
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  32  new fetch PC

Behaviour:
- Reset (rst_n=0 at edge): state=BOOT, fetch_pc=RESET_PC, inflight=0, drop_cnt=0, buffer empty. Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC. Reset mid-transaction abandons everything; late responses after reset are dropped only if the memory is also reset.
- FSM: BOOT -> RUN after one cycle with no request. RUN is the steady state. TRAP is reachable only with the optional feature.
- Request: in RUN, imem_req_valid = (inflight + count < DEPTH) && !redirect_valid. imem_req_addr = fetch_pc. Addr is stable while valid && !ready.
- On request fire: fetch_pc += 4, modulo 2^32 (0xFFFF_FFFC wraps to 0). inflight += 1.
- Response: each imem_rsp_valid decrements inflight. If drop_cnt>0, decrement drop_cnt and discard the word. Otherwise push {data, pc} into the buffer; pc is tracked by a per-entry PC queue or an issue-PC counter.
- Decode handshake: instr_valid = count>0. Pop on instr_valid && instr_ready. Push and pop in the same cycle are both allowed when full or empty, as a bypass-free FIFO. Zero-cycle fall-through from memory to decode is not provided; min latency is request accept -> rsp -> instr_valid the next cycle.
- Redirect takes priority over all same-cycle events:
  - buffer cleared; the same-cycle pop is ignored and the rsp word is not pushed;
  - drop_cnt <= inflight - (rsp fire ? 1:0);
  - fetch_pc <= {redirect_pc[31:2], 2'b00}; no request that cycle.
- Back-to-back redirects: the latest wins; drop_cnt is recomputed each time.
- Invariant: inflight + count <= DEPTH. No overflow is possible because memory never returns unrequested words.

Optional Feature:
FETCH_MISALIGN_TRAP_EN.
- Defined: adds output instr_misaligned (1 bit, reset 0). A redirect with redirect_pc[1:0]!=0 flushes as usual, then enters TRAP. TRAP issues no requests. Once drops drain, it presents one entry: instr=NOP, instr_pc=redirect_pc (unmasked), instr_misaligned=1, held until popped. It then stays in TRAP with instr_valid=0 until the next redirect, which returns it to RUN (or TRAP again if misaligned).
- Undefined: no port, no TRAP state; low two bits silently zeroed.

Decomposition:
- Shared package fetch_pkg: NOP_INSTR=32'h0000_0013, PC_STEP=4, fetch_state_t {BOOT, RUN, TRAP}.
- One natural sub-module: fetch_buffer, a DEPTH-entry sync FIFO of {instr, pc} with push/pop/flush/count. The fetch unit keeps the FSM, fetch_pc, inflight and drop_cnt.

Test Plan:
- Reset, 1-cycle-latency memory, instr_ready=1 -> first imem_req_addr=0x0 one cycle after BOOT; decode sees pcs 0x0, 0x4, 0x8... in order with matching data.
- instr_ready=0 for 10 cycles -> exactly 2 words buffered, imem_req_valid=0, no further requests; release gives contiguous pcs, nothing lost.
- Memory latency 3, redirect to 0x100 while 2 requests in flight -> both stale responses discarded; first instr_pc=0x100.
- Redirect in the same cycle as rsp_valid and pop -> rsp word discarded, drop_cnt=inflight-1, buffer empty the next cycle.
- RESET_PC=0xFFFF_FFF8 -> pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- With FETCH_MISALIGN_TRAP_EN, redirect_pc=0x102 -> one entry with instr_misaligned=1, instr_pc=0x102, then no requests until a redirect to 0x200 resumes fetch at 0x200. Without the macro, fetch resumes at 0x100.
